// File: rtl/mips_pkg.sv
// Shared register-file write types and widths.
package mips_pkg;
    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam logic [RADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [RADDR_W-1:0] wa;
        logic [XLEN-1:0]    wd;
    } wb_req_t;
endpackage

// File: rtl/wb_write_arbiter_if.sv
// Write-back bus: primary/secondary sources in, register-file port and hazard info out.
interface wb_write_arbiter_if;
    import mips_pkg::*;

    logic               pri_wen;
    logic [RADDR_W-1:0] pri_wa;
    logic [XLEN-1:0]    pri_wd;
    logic               sec_valid;
    logic [RADDR_W-1:0] sec_wa;
    logic [XLEN-1:0]    sec_wd;
    logic               sec_ready;
    logic               rf_wen;
    logic [RADDR_W-1:0] rf_wa;
    logic [XLEN-1:0]    rf_wd;
    logic               stall_req;
    logic [31:0]        busy_mask;
    logic               proto_err;

    modport master (
        output pri_wen, pri_wa, pri_wd, sec_valid, sec_wa, sec_wd,
        input  sec_ready, rf_wen, rf_wa, rf_wd, stall_req, busy_mask, proto_err
    );

    modport slave (
        input  pri_wen, pri_wa, pri_wd, sec_valid, sec_wa, sec_wd,
        output sec_ready, rf_wen, rf_wa, rf_wd, stall_req, busy_mask, proto_err
    );
endinterface

// File: rtl/wb_write_arbiter_fifo.sv
// Synchronous FIFO of write requests; exposes every slot and its valid bit for hazard decode.
module wb_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  wb_req_t                push_data,
    input  logic                   pop,
    output wb_req_t                head,
    output logic                   full,
    output logic                   empty,
    output logic [DEPTH-1:0]       entry_vld,
    output wb_req_t [DEPTH-1:0]    entries
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]            wr_ptr, rd_ptr, count;
    wb_req_t [DEPTH-1:0]    mem;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: only slots between the pointers are ever observed.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head    = mem[rd_ptr[AW-1:0]];
    assign entries = mem;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;

    // A slot is live when its distance from the read pointer is below occupancy.
    always_comb begin
        entry_vld = '0;
        for (int i = 0; i < DEPTH; i++)
            entry_vld[i] = ({1'b0, AW'(i) - rd_ptr[AW-1:0]} < count);
    end
endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: primary pipeline wins, queued mul/div results fill
// idle cycles, and a starvation counter forces a one-cycle pipeline stall to drain.
module wb_write_arbiter
    import mips_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic               clock,
    input  logic               reset,
    wb_write_arbiter_if.slave  bus
);
    logic               pri_wen_eff, push, pop, full, empty, stall;
    logic               sel_vld;
    wb_req_t            sel_req, head;
    logic [DEPTH-1:0]   entry_vld;
    wb_req_t [DEPTH-1:0] entries;
    logic [CNT_W-1:0]   cnt_q;
    logic               rf_wen_q, proto_q;
    logic [RADDR_W-1:0] rf_wa_q;
    logic [XLEN-1:0]    rf_wd_q;

    assign pri_wen_eff = bus.pri_wen && (bus.pri_wa != REG_ZERO);
    assign stall       = (cnt_q == CNT_W'(STARVE_LIMIT));

    // $0 results still complete the handshake but never occupy a slot.
    assign push = bus.sec_valid && !full && (bus.sec_wa != REG_ZERO);
    assign pop  = !empty && (stall || !pri_wen_eff);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data ({bus.sec_wa, bus.sec_wd}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .entry_vld (entry_vld),
        .entries   (entries)
    );

    always_comb begin
        sel_vld = 1'b0;
        sel_req = head;
        if (pop) begin
            sel_vld = 1'b1;
        end else if (pri_wen_eff) begin
            sel_vld = 1'b1;
            sel_req = '{wa: bus.pri_wa, wd: bus.pri_wd};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rf_wen_q <= 1'b0;
            rf_wa_q  <= '0;
            rf_wd_q  <= '0;
        end else begin
            rf_wen_q <= sel_vld;
            if (sel_vld) begin
                rf_wa_q <= sel_req.wa;
                rf_wd_q <= sel_req.wd;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            proto_q <= 1'b0;
        end else begin
            if (empty || pop)    cnt_q <= '0;
            else if (!stall)     cnt_q <= cnt_q + 1'b1;
            if (stall && bus.pri_wen) proto_q <= 1'b1;
        end
    end

    always_comb begin
        bus.busy_mask = '0;
        for (int i = 0; i < DEPTH; i++)
            if (entry_vld[i]) bus.busy_mask[entries[i].wa] = 1'b1;
        bus.busy_mask[0] = 1'b0;
    end

    assign bus.sec_ready = !full;
    assign bus.stall_req = stall;
    assign bus.proto_err = proto_q;
    assign bus.rf_wen    = rf_wen_q;
    assign bus.rf_wa     = rf_wa_q;
    assign bus.rf_wd     = rf_wd_q;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scenario bench for wb_write_arbiter; a monitor checks every rf write against a scoreboard queue.
module tb_wb_write_arbiter;
    import mips_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    wb_req_t exp_q[$];
    wb_req_t mon_e;

    wb_write_arbiter_if bus ();

    wb_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(3), .CNT_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Scoreboard: every register-file write must match the next expected entry.
    always @(posedge clock) begin
        #2;
        if (bus.rf_wen === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rf_write unexpected: got wa=%0d wd=%h, expected none", bus.rf_wa, bus.rf_wd);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.rf_wa !== mon_e.wa || bus.rf_wd !== mon_e.wd) begin
                    bad++;
                    $display("FAIL rf_write: got wa=%0d wd=%h, expected wa=%0d wd=%h",
                             bus.rf_wa, bus.rf_wd, mon_e.wa, mon_e.wd);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                         input logic sv, input logic [4:0] sa, input logic [31:0] sd);
        bus.pri_wen = pw; bus.pri_wa = pa; bus.pri_wd = pd;
        bus.sec_valid = sv; bus.sec_wa = sa; bus.sec_wd = sd;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        total++;
        if (bus.rf_wen !== 1'b0 || bus.rf_wa !== 5'd0 || bus.rf_wd !== 32'd0) begin
            bad++; $display("FAIL reset_rf: got wen=%b wa=%0d wd=%h, expected 0/0/0", bus.rf_wen, bus.rf_wa, bus.rf_wd);
        end
        total++;
        if (bus.busy_mask !== 32'd0 || bus.stall_req !== 1'b0 || bus.proto_err !== 1'b0) begin
            bad++; $display("FAIL reset_status: got busy=%h stall=%b perr=%b, expected 0/0/0", bus.busy_mask, bus.stall_req, bus.proto_err);
        end
        tick(); tick();
        @(negedge clock) reset = 1'b1;
        tick();
        total++;
        if (bus.sec_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready: got %b, expected 1", bus.sec_ready);
        end
    endtask

    task automatic test_primary();
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
        exp_q.push_back('{wa: 5'd5, wd: 32'hDEADBEEF});
        tick();
        total++;
        if (bus.rf_wen !== 1'b1 || bus.rf_wa !== 5'd5 || bus.rf_wd !== 32'hDEADBEEF || bus.busy_mask !== 32'd0) begin
            bad++; $display("FAIL primary: got wen=%b wa=%0d wd=%h busy=%h, expected 1/5/deadbeef/0",
                            bus.rf_wen, bus.rf_wa, bus.rf_wd, bus.busy_mask);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        total++;
        if (bus.rf_wen !== 1'b0 || bus.rf_wa !== 5'd5) begin
            bad++; $display("FAIL primary_idle: got wen=%b wa=%0d, expected 0/5", bus.rf_wen, bus.rf_wa);
        end
    endtask

    task automatic test_secondary();
        drive(0, 0, 0, 1, 9, 32'h11);
        exp_q.push_back('{wa: 5'd9, wd: 32'h11});
        tick();
        total++;
        if (bus.busy_mask !== 32'h200 || bus.rf_wen !== 1'b0) begin
            bad++; $display("FAIL sec_push1: got busy=%h wen=%b, expected 200/0", bus.busy_mask, bus.rf_wen);
        end
        drive(0, 0, 0, 1, 10, 32'h22);
        exp_q.push_back('{wa: 5'd10, wd: 32'h22});
        tick();
        total++;
        if (bus.rf_wa !== 5'd9 || bus.rf_wen !== 1'b1 || bus.busy_mask !== 32'h400) begin
            bad++; $display("FAIL sec_pop1: got wa=%0d wen=%b busy=%h, expected 9/1/400", bus.rf_wa, bus.rf_wen, bus.busy_mask);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        total++;
        if (bus.rf_wa !== 5'd10 || bus.rf_wen !== 1'b1 || bus.busy_mask !== 32'd0) begin
            bad++; $display("FAIL sec_pop2: got wa=%0d wen=%b busy=%h, expected 10/1/0", bus.rf_wa, bus.rf_wen, bus.busy_mask);
        end
        tick();
    endtask

    task automatic test_starve();
        total++;
        if (bus.proto_err !== 1'b0) begin
            bad++; $display("FAIL starve_pre_perr: got %b, expected 0", bus.proto_err);
        end
        drive(1, 3, 32'hA0, 1, 7, 32'h77);
        exp_q.push_back('{wa: 5'd3, wd: 32'hA0});
        tick();
        total++;
        if (bus.busy_mask !== 32'h80 || bus.stall_req !== 1'b0) begin
            bad++; $display("FAIL starve_push: got busy=%h stall=%b, expected 80/0", bus.busy_mask, bus.stall_req);
        end
        for (int k = 1; k <= 3; k++) begin
            drive(1, 3, 32'hA0 + k, 0, 0, 0);
            exp_q.push_back('{wa: 5'd3, wd: 32'hA0 + k});
            tick();
            total++;
            if (bus.stall_req !== (k == 3)) begin
                bad++; $display("FAIL starve_stall k=%0d: got %b, expected %b", k, bus.stall_req, (k == 3));
            end
        end
        drive(1, 3, 32'hBAD, 0, 0, 0);
        exp_q.push_back('{wa: 5'd7, wd: 32'h77});
        tick();
        total++;
        if (bus.rf_wa !== 5'd7 || bus.rf_wd !== 32'h77 || bus.proto_err !== 1'b1 ||
            bus.stall_req !== 1'b0 || bus.busy_mask !== 32'd0) begin
            bad++; $display("FAIL starve_drain: got wa=%0d wd=%h perr=%b stall=%b busy=%h, expected 7/77/1/0/0",
                            bus.rf_wa, bus.rf_wd, bus.proto_err, bus.stall_req, bus.busy_mask);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++) begin
            drive(1, 4, 32'hB0 + k, 1, 5'(11 + k), 32'hC0 + k);
            total++;
            if (bus.sec_ready !== 1'b1) begin
                bad++; $display("FAIL full_ready k=%0d: got %b, expected 1", k, bus.sec_ready);
            end
            exp_q.push_back('{wa: 5'd4, wd: 32'hB0 + k});
            tick();
        end
        total++;
        if (bus.sec_ready !== 1'b0 || bus.stall_req !== 1'b1 || bus.busy_mask !== 32'h7800) begin
            bad++; $display("FAIL full_state: got ready=%b stall=%b busy=%h, expected 0/1/7800",
                            bus.sec_ready, bus.stall_req, bus.busy_mask);
        end
        drive(1, 4, 32'hBAD, 1, 15, 32'hCF);
        exp_q.push_back('{wa: 5'd11, wd: 32'hC0});
        tick();
        total++;
        if (bus.rf_wa !== 5'd11 || bus.sec_ready !== 1'b1 || bus.stall_req !== 1'b0 || bus.busy_mask !== 32'h7000) begin
            bad++; $display("FAIL full_pop: got wa=%0d ready=%b stall=%b busy=%h, expected 11/1/0/7000",
                            bus.rf_wa, bus.sec_ready, bus.stall_req, bus.busy_mask);
        end
        drive(1, 4, 32'hB4, 1, 15, 32'hCF);
        exp_q.push_back('{wa: 5'd4, wd: 32'hB4});
        tick();
        total++;
        if (bus.sec_ready !== 1'b0 || bus.busy_mask !== 32'hF000) begin
            bad++; $display("FAIL full_fifth: got ready=%b busy=%h, expected 0/f000", bus.sec_ready, bus.busy_mask);
        end
        drive(0, 0, 0, 0, 0, 0);
        exp_q.push_back('{wa: 5'd12, wd: 32'hC1});
        exp_q.push_back('{wa: 5'd13, wd: 32'hC2});
        exp_q.push_back('{wa: 5'd14, wd: 32'hC3});
        exp_q.push_back('{wa: 5'd15, wd: 32'hCF});
        repeat (4) tick();
        total++;
        if (bus.busy_mask !== 32'd0 || bus.sec_ready !== 1'b1 || bus.proto_err !== 1'b1) begin
            bad++; $display("FAIL full_drain: got busy=%h ready=%b perr=%b, expected 0/1/1",
                            bus.busy_mask, bus.sec_ready, bus.proto_err);
        end
        tick();
    endtask

    task automatic test_zero();
        drive(1, 0, 32'h1234, 1, 0, 32'h5678);
        total++;
        if (bus.sec_ready !== 1'b1) begin
            bad++; $display("FAIL zero_ready: got %b, expected 1", bus.sec_ready);
        end
        tick();
        total++;
        if (bus.rf_wen !== 1'b0 || bus.busy_mask !== 32'd0) begin
            bad++; $display("FAIL zero_filter: got wen=%b busy=%h, expected 0/0", bus.rf_wen, bus.busy_mask);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        total++;
        if (bus.rf_wen !== 1'b0) begin
            bad++; $display("FAIL zero_after: got wen=%b, expected 0", bus.rf_wen);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            drive(1, 2, 32'hD0 + k, 1, 5'(21 + k), 32'hE0 + k);
            exp_q.push_back('{wa: 5'd2, wd: 32'hD0 + k});
            tick();
        end
        total++;
        if (bus.busy_mask !== 32'hE00000) begin
            bad++; $display("FAIL mid_busy: got %h, expected e00000", bus.busy_mask);
        end
        drive(0, 0, 0, 0, 0, 0);
        exp_q.push_back('{wa: 5'd21, wd: 32'hE0});
        tick();
        total++;
        if (bus.rf_wa !== 5'd21 || bus.rf_wen !== 1'b1) begin
            bad++; $display("FAIL mid_pop: got wa=%0d wen=%b, expected 21/1", bus.rf_wa, bus.rf_wen);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if (bus.rf_wen !== 1'b0 || bus.rf_wa !== 5'd0 || bus.rf_wd !== 32'd0 ||
            bus.busy_mask !== 32'd0 || bus.stall_req !== 1'b0 || bus.proto_err !== 1'b0) begin
            bad++; $display("FAIL mid_reset: got wen=%b wa=%0d wd=%h busy=%h stall=%b perr=%b, expected all 0",
                            bus.rf_wen, bus.rf_wa, bus.rf_wd, bus.busy_mask, bus.stall_req, bus.proto_err);
        end
        tick(); tick();
        @(negedge clock) reset = 1'b1;
        tick();
        total++;
        if (bus.sec_ready !== 1'b1 || bus.busy_mask !== 32'd0) begin
            bad++; $display("FAIL mid_release: got ready=%b busy=%h, expected 1/0", bus.sec_ready, bus.busy_mask);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (bus.rf_wen !== 1'b0) begin
                bad++; $display("FAIL mid_stale k=%0d: got wen=%b wa=%0d, expected wen 0", k, bus.rf_wen, bus.rf_wa);
            end
        end
    endtask

    initial begin
        test_reset();
        test_primary();
        test_secondary();
        test_starve();
        test_full();
        test_zero();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
